// File: rtl/ex_ctrl_pipe_if.sv
// Control bundle between the execute stage and ex_ctrl_pipe.
// occ_o exists only when EX_PIPE_OCC_EN is defined.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COND_CODE_WIDTH
`define COND_CODE_WIDTH 4
`endif
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 16
`endif

interface ex_ctrl_pipe_if #(parameter int DEPTH = 2);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                        valid_i;
    logic                        stall_i;
    logic                        flush_i;
    logic                        dm_re_i;
    logic                        regfile_we_w_i;
    logic                        regfile_we_uhw_i;
    logic                        branchen_i;
    logic                        sr_we_i;
    logic [`REG_ADDR_WIDTH-1:0]  addr_rd_i;
    logic [`COND_CODE_WIDTH-1:0] condcode_i;
    logic [`IM_ADDR_WIDTH-1:0]   branchtrgt_i;

    logic                        valid_o;
    logic                        dm_re_o;
    logic                        regfile_we_w_o;
    logic                        regfile_we_uhw_o;
    logic                        branchen_o;
    logic                        sr_we_o;
    logic [`REG_ADDR_WIDTH-1:0]  addr_rd_o;
    logic [`COND_CODE_WIDTH-1:0] condcode_o;
    logic [`IM_ADDR_WIDTH-1:0]   branchtrgt_o;
`ifdef EX_PIPE_OCC_EN
    logic [OCC_W-1:0]            occ_o;
`endif

    modport master (
`ifdef EX_PIPE_OCC_EN
        input  occ_o,
`endif
        output valid_i, stall_i, flush_i, dm_re_i, regfile_we_w_i, regfile_we_uhw_i,
               branchen_i, sr_we_i, addr_rd_i, condcode_i, branchtrgt_i,
        input  valid_o, dm_re_o, regfile_we_w_o, regfile_we_uhw_o, branchen_o,
               sr_we_o, addr_rd_o, condcode_o, branchtrgt_o
    );

    modport slave (
`ifdef EX_PIPE_OCC_EN
        output occ_o,
`endif
        input  valid_i, stall_i, flush_i, dm_re_i, regfile_we_w_i, regfile_we_uhw_i,
               branchen_i, sr_we_i, addr_rd_i, condcode_i, branchtrgt_i,
        output valid_o, dm_re_o, regfile_we_w_o, regfile_we_uhw_o, branchen_o,
               sr_we_o, addr_rd_o, condcode_o, branchtrgt_o
    );
endinterface

// File: rtl/ex_ctrl_pipe.sv
// DEPTH-stage control delay line with stall/flush; EX_PIPE_OCC_EN adds a
// registered occupancy counter on occ_o.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COND_CODE_WIDTH
`define COND_CODE_WIDTH 4
`endif
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 16
`endif

module ex_ctrl_pipe #(
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    ex_ctrl_pipe_if.slave bus
);
    typedef struct packed {
        logic                        valid;
        logic                        dm_re;
        logic                        we_w;
        logic                        we_uhw;
        logic                        branchen;
        logic                        sr_we;
        logic [`REG_ADDR_WIDTH-1:0]  addr_rd;
        logic [`COND_CODE_WIDTH-1:0] condcode;
        logic [`IM_ADDR_WIDTH-1:0]   branchtrgt;
    } entry_t;

    entry_t entry_in;
    entry_t stage_q [DEPTH];

    // A bubble enters as an all-zero entry, so no enable can leak through it.
    always_comb begin
        entry_in = '0;
        if (bus.valid_i) begin
            entry_in.valid      = 1'b1;
            entry_in.dm_re      = bus.dm_re_i;
            entry_in.we_w       = bus.regfile_we_w_i;
            entry_in.we_uhw     = bus.regfile_we_uhw_i;
            entry_in.branchen   = bus.branchen_i;
            entry_in.sr_we      = bus.sr_we_i;
            entry_in.addr_rd    = bus.addr_rd_i;
            entry_in.condcode   = bus.condcode_i;
            entry_in.branchtrgt = bus.branchtrgt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else if (!bus.stall_i) begin
            stage_q[0] <= entry_in;
            for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        end
    end

    // Outputs come straight from the last stage register.
    assign bus.valid_o          = stage_q[DEPTH-1].valid;
    assign bus.dm_re_o          = stage_q[DEPTH-1].dm_re;
    assign bus.regfile_we_w_o   = stage_q[DEPTH-1].we_w;
    assign bus.regfile_we_uhw_o = stage_q[DEPTH-1].we_uhw;
    assign bus.branchen_o       = stage_q[DEPTH-1].branchen;
    assign bus.sr_we_o          = stage_q[DEPTH-1].sr_we;
    assign bus.addr_rd_o        = stage_q[DEPTH-1].addr_rd;
    assign bus.condcode_o       = stage_q[DEPTH-1].condcode;
    assign bus.branchtrgt_o     = stage_q[DEPTH-1].branchtrgt;

`ifdef EX_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);
    logic [OCC_W-1:0] occ_q;

    // Entering and leaving valid entries on the same advance cancel out.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            occ_q <= '0;
        end else if (!bus.stall_i) begin
            occ_q <= occ_q + OCC_W'(entry_in.valid) - OCC_W'(stage_q[DEPTH-1].valid);
        end
    end

    assign bus.occ_o = occ_q;
`endif
endmodule

// File: tb/tb_ex_ctrl_pipe.sv
// Bench for ex_ctrl_pipe: DEPTH 1..4 instances share one stimulus stream and
// are checked every cycle against a history-based model plus literal expectations.
`timescale 1ns/1ps
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COND_CODE_WIDTH
`define COND_CODE_WIDTH 4
`endif
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 16
`endif

module tb_ex_ctrl_pipe;
    localparam int RA = `REG_ADDR_WIDTH;
    localparam int CW = `COND_CODE_WIDTH;
    localparam int TW = `IM_ADDR_WIDTH;
    localparam int EW = 6 + RA + CW + TW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid_i, stall_i, flush_i;
    logic [4:0]    en;  // {dm_re, we_w, we_uhw, branchen, sr_we}
    logic [RA-1:0] addr;
    logic [CW-1:0] cc;
    logic [TW-1:0] tgt;

    logic [EW-1:0] out_vec [1:4];
`ifdef EX_PIPE_OCC_EN
    logic [3:0]    occ_v [1:4];
`endif

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar g = 1; g <= 4; g++) begin : g_d
        ex_ctrl_pipe_if #(.DEPTH(g)) bus ();
        assign bus.valid_i          = valid_i;
        assign bus.stall_i          = stall_i;
        assign bus.flush_i          = flush_i;
        assign bus.dm_re_i          = en[4];
        assign bus.regfile_we_w_i   = en[3];
        assign bus.regfile_we_uhw_i = en[2];
        assign bus.branchen_i       = en[1];
        assign bus.sr_we_i          = en[0];
        assign bus.addr_rd_i        = addr;
        assign bus.condcode_i       = cc;
        assign bus.branchtrgt_i     = tgt;
        ex_ctrl_pipe #(.DEPTH(g)) dut (.clk(clk), .rst(rst), .bus(bus));
        assign out_vec[g] = {bus.valid_o, bus.dm_re_o, bus.regfile_we_w_o, bus.regfile_we_uhw_o,
                             bus.branchen_o, bus.sr_we_o, bus.addr_rd_o, bus.condcode_o,
                             bus.branchtrgt_o};
`ifdef EX_PIPE_OCC_EN
        assign occ_v[g] = 4'(bus.occ_o);
`endif
    end

    // Model: the list of entries accepted since the last rst/flush. A DEPTH-d
    // pipe shows the entry accepted d advances ago, or zeros if none exists.
    logic [EW-1:0] hist [$];

    function automatic logic [EW-1:0] expect_out(int d);
        if (hist.size() < d) return '0;
        return hist[hist.size() - d];
    endfunction

    function automatic int expect_occ(int d);
        int c = 0;
        for (int i = 0; i < d && i < hist.size(); i++) c += int'(hist[hist.size()-1-i][EW-1]);
        return c;
    endfunction

    task automatic model_update();
        logic [EW-1:0] e;
        if (rst || flush_i) begin
            hist.delete();
        end else if (!stall_i) begin
            e = valid_i ? {1'b1, en, addr, cc, tgt} : '0;
            hist.push_back(e);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_all();
        for (int d = 1; d <= 4; d++) begin
            chk($sformatf("pipe_d%0d", d), 32'(out_vec[d]), 32'(expect_out(d)));
`ifdef EX_PIPE_OCC_EN
            chk($sformatf("occ_d%0d", d), 32'(occ_v[d]), 32'(expect_occ(d)));
`endif
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic f,
                        input logic [4:0] e, input int a, input int c, input int t);
        rst = r; valid_i = v; stall_i = s; flush_i = f; en = e;
        addr = RA'(a); cc = CW'(c); tgt = TW'(t);
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'b0, 0, 0, 0);
    endtask

`ifdef EX_PIPE_OCC_EN
    int occ_exp [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
`endif

    initial begin
        // Reset
        step(1, 1, 0, 0, 5'b11111, 7, 7, 7);
        step(1, 0, 0, 0, 5'b0, 0, 0, 0);
        chk("rst_d3_valid", 32'(out_vec[3][EW-1]), 0);
        chk("rst_d3_all", 32'(out_vec[3]), 0);

        // Single instruction through DEPTH=2
        step(0, 1, 0, 0, 5'b01000, 5, 0, 0);
        chk("d1_lat1_addr", 32'(out_vec[1][TW+CW +: RA]), 5);
        step(0, 0, 0, 0, 5'b0, 0, 0, 0);
        chk("d2_valid", 32'(out_vec[2][EW-1]), 1);
        chk("d2_we_w", 32'(out_vec[2][EW-3]), 1);
        chk("d2_addr", 32'(out_vec[2][TW+CW +: RA]), 5);
        step(0, 0, 0, 0, 5'b0, 0, 0, 0);
        chk("d2_after_valid", 32'(out_vec[2][EW-1]), 0);
        idle(3);

        // A,B,C then two stalls on DEPTH=3; the stalled input slot is discarded
        step(0, 1, 0, 0, 5'b10000, 1, 1, 'h100);
        step(0, 1, 0, 0, 5'b00100, 2, 2, 'h200);
        step(0, 1, 0, 0, 5'b00001, 3, 3, 'h300);
        chk("d3_A_addr", 32'(out_vec[3][TW+CW +: RA]), 1);
        step(0, 1, 1, 0, 5'b11111, 9, 9, 'h999);
        chk("d3_stall1_addr", 32'(out_vec[3][TW+CW +: RA]), 1);
        step(0, 1, 1, 0, 5'b11111, 9, 9, 'h999);
        chk("d3_stall2_addr", 32'(out_vec[3][TW+CW +: RA]), 1);
        step(0, 0, 0, 0, 5'b0, 0, 0, 0);
        chk("d3_B_addr", 32'(out_vec[3][TW+CW +: RA]), 2);
        step(0, 0, 0, 0, 5'b0, 0, 0, 0);
        chk("d3_C_addr", 32'(out_vec[3][TW+CW +: RA]), 3);
        chk("d3_C_trgt", 32'(out_vec[3][TW-1:0]), 'h300);
        step(0, 0, 0, 0, 5'b0, 0, 0, 0);
        chk("d3_drained_valid", 32'(out_vec[3][EW-1]), 0);

        // Full pipe, flush together with stall
        step(0, 1, 0, 0, 5'b11111, 4, 5, 'h1234);
        step(0, 1, 0, 0, 5'b11111, 5, 6, 'h2345);
        step(0, 1, 0, 0, 5'b11111, 6, 7, 'h3456);
        chk("d3_full_valid", 32'(out_vec[3][EW-1]), 1);
        step(0, 1, 1, 1, 5'b11111, 8, 8, 'h4567);
        chk("flush_d3_all", 32'(out_vec[3]), 0);
        chk("flush_d3_trgt", 32'(out_vec[3][TW-1:0]), 0);
`ifdef EX_PIPE_OCC_EN
        chk("flush_d3_occ", 32'(occ_v[3]), 0);
`endif

        // Bubble carrying asserted enables
        step(0, 0, 0, 0, 5'b11111, 31, 3, 'hffff);
        step(0, 0, 0, 0, 5'b0, 0, 0, 0);
        chk("bubble_d2_all", 32'(out_vec[2]), 0);

        // Reset while stalled with a full pipe
        step(0, 1, 0, 0, 5'b10101, 10, 1, 'h11);
        step(0, 1, 0, 0, 5'b01010, 11, 2, 'h22);
        step(0, 1, 0, 0, 5'b11111, 12, 3, 'h33);
        step(0, 1, 0, 0, 5'b00011, 13, 4, 'h44);
        chk("d4_full_addr", 32'(out_vec[4][TW+CW +: RA]), 10);
        step(1, 1, 1, 0, 5'b11111, 14, 5, 'h55);
        chk("rst_stall_d3", 32'(out_vec[3]), 0);
        chk("rst_stall_d4", 32'(out_vec[4]), 0);
`ifdef EX_PIPE_OCC_EN
        chk("rst_stall_occ4", 32'(occ_v[4]), 0);
`endif

        // Occupancy ramp on DEPTH=4: five valid issues, then four bubbles
        for (int i = 0; i < 9; i++) begin
            if (i < 5) step(0, 1, 0, 0, 5'b01000, 16 + i, 0, i);
            else       step(0, 0, 0, 0, 5'b0, 0, 0, 0);
`ifdef EX_PIPE_OCC_EN
            chk($sformatf("occ_ramp%0d", i), 32'(occ_v[4]), 32'(occ_exp[i]));
`endif
        end

        // Mixed traffic with interleaved stalls, bubbles and one flush
        for (int i = 0; i < 24; i++) begin
            step(0, (i % 3) != 2, (i % 5) == 3, i == 17, 5'(i * 7), i, i, i * 37);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
